mbisr_repair_engine: RTL and testbench

//   Next-gen MBISR repair controller between MBIST and the user RAM port. Accepts

---
 rtl/mbisr_repair_engine.sv | 158 +++++++++++++++
 tb/tb_mbisr_repair_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mbisr_repair_engine.sv
// rtl/mbisr_repair_engine.sv - MBISR repair engine: dedup failing addresses, allocate spare rows, remap user port
module mbisr_repair_engine #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_REPAIRS = 16,
    parameter logic [ADDR_WIDTH-1:0] SPARE_BASE = 'hF0,
    localparam int CW = $clog2(MAX_REPAIRS + 1),
    localparam int IW = $clog2(MAX_REPAIRS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fail_valid,
    output logic                  fail_ready,
    input  logic [ADDR_WIDTH-1:0] fail_addr,
    input  logic                  lock,
    input  logic                  clear,
    output logic [CW-1:0]         repair_count,
    output logic                  repair_full,
    output logic                  repair_overflow,
    output logic                  spare_fault,
    input  logic [IW-1:0]         rd_idx,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] user_addr,
    input  logic [DATA_WIDTH-1:0] user_wdata,
    input  logic                  user_we,
    input  logic                  user_en,
    output logic [DATA_WIDTH-1:0] user_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic {ST_IDLE, ST_CHECK} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_pend_addr;
    logic [ADDR_WIDTH-1:0]   r_table [MAX_REPAIRS];
    logic [MAX_REPAIRS-1:0]  r_valid;
    logic [CW-1:0]           r_count;
    logic                    r_overflow;
    logic                    r_spare_fault;

    logic                    w_accept;
    logic                    w_set_spare;
    logic                    w_set_ovf;
    logic                    w_alloc;
    logic                    w_dup;
    logic                    w_full;
    logic                    w_in_spare;
    logic [ADDR_WIDTH-1:0]   w_spare_off;

    // Modular offset from the spare base, so a base near the top of the space wraps correctly
    assign w_spare_off = r_pend_addr - SPARE_BASE;
    assign w_in_spare  = 32'(w_spare_off) < 32'(MAX_REPAIRS);
    assign w_full      = (r_count == CW'(MAX_REPAIRS));

    always_comb begin
        w_dup = 1'b0;
        for (int k = 0; k < MAX_REPAIRS; k++) begin
            if (r_valid[k] && (r_table[k] == r_pend_addr)) w_dup = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        fail_ready   = 1'b0;
        w_accept     = 1'b0;
        w_set_spare  = 1'b0;
        w_set_ovf    = 1'b0;
        w_alloc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                fail_ready = !lock && !clear;
                w_accept   = fail_valid && fail_ready;
                if (w_accept) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                w_next_state = ST_IDLE;
                if (!clear) begin
                    if (w_in_spare)   w_set_spare = 1'b1;
                    else if (w_dup)   w_set_spare = 1'b0;
                    else if (w_full)  w_set_ovf   = 1'b1;
                    else              w_alloc     = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (clear) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_addr   <= '0;
            r_valid       <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_spare_fault <= 1'b0;
            for (int k = 0; k < MAX_REPAIRS; k++) r_table[k] <= '1;
        end else begin
            if (w_accept) r_pend_addr <= fail_addr;
            if (clear) begin
                r_valid       <= '0;
                r_count       <= '0;
                r_overflow    <= 1'b0;
                r_spare_fault <= 1'b0;
                for (int k = 0; k < MAX_REPAIRS; k++) r_table[k] <= '1;
            end else begin
                if (w_set_spare) r_spare_fault <= 1'b1;
                if (w_set_ovf)   r_overflow    <= 1'b1;
                if (w_alloc) begin
                    r_count <= r_count + CW'(1);
                    for (int k = 0; k < MAX_REPAIRS; k++) begin
                        if (r_count == CW'(k)) begin
                            r_table[k] <= r_pend_addr;
                            r_valid[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Entries are unique, so at most one index can hit
    always_comb begin
        mem_addr = user_addr;
        for (int k = 0; k < MAX_REPAIRS; k++) begin
            if (r_valid[k] && (r_table[k] == user_addr)) mem_addr = SPARE_BASE + ADDR_WIDTH'(k);
        end
    end

    always_comb begin
        rd_addr  = '1;
        rd_valid = 1'b0;
        for (int k = 0; k < MAX_REPAIRS; k++) begin
            if (rd_idx == IW'(k)) begin
                rd_addr  = r_table[k];
                rd_valid = r_valid[k];
            end
        end
    end

    assign repair_count    = r_count;
    assign repair_full     = w_full;
    assign repair_overflow = r_overflow;
    assign spare_fault     = r_spare_fault;
    assign user_rdata      = mem_rdata;
    assign mem_wdata       = user_wdata;
    assign mem_we          = user_we;
    assign mem_en          = user_en;
endmodule

// File: tb/tb_mbisr_repair_engine.sv
// tb/tb_mbisr_repair_engine.sv - directed self-checking bench for mbisr_repair_engine
module tb_mbisr_repair_engine;
    logic       clk = 1'b0;
    logic       rst;
    logic       fail_valid;
    logic       fail_ready;
    logic [7:0] fail_addr;
    logic       lock;
    logic       clear;
    logic [4:0] repair_count;
    logic       repair_full;
    logic       repair_overflow;
    logic       spare_fault;
    logic [3:0] rd_idx;
    logic [7:0] rd_addr;
    logic       rd_valid;
    logic [7:0] user_addr;
    logic [7:0] user_wdata;
    logic       user_we;
    logic       user_en;
    logic [7:0] user_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_en;
    logic [7:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mbisr_repair_engine dut (
        .clk(clk), .rst(rst),
        .fail_valid(fail_valid), .fail_ready(fail_ready), .fail_addr(fail_addr),
        .lock(lock), .clear(clear),
        .repair_count(repair_count), .repair_full(repair_full),
        .repair_overflow(repair_overflow), .spare_fault(spare_fault),
        .rd_idx(rd_idx), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .user_addr(user_addr), .user_wdata(user_wdata), .user_we(user_we), .user_en(user_en),
        .user_rdata(user_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_fail(input logic [7:0] a);
        int t;
        t = 0;
        fail_addr  = a;
        fail_valid = 1'b1;
        #1;
        while (!fail_ready && t < 10) begin
            tick();
            t++;
        end
        chk("ready_wait", 32'(t < 10), 32'd1);
        tick();
        fail_valid = 1'b0;
        tick();
    endtask

    task automatic check_map(input string tag, input logic [7:0] ua, input logic [7:0] exp);
        user_addr = ua;
        #1;
        chk(tag, 32'(mem_addr), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; fail_valid = 1'b0; fail_addr = 8'h00; lock = 1'b0; clear = 1'b0;
        rd_idx = 4'd0; user_addr = 8'h00; user_wdata = 8'h00; user_we = 1'b0; user_en = 1'b0;
        mem_rdata = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("reset_count", 32'(repair_count), 32'd0);
        chk("reset_ready", 32'(fail_ready), 32'd1);
        chk("reset_full", 32'(repair_full), 32'd0);
        chk("reset_ovf", 32'(repair_overflow), 32'd0);
        chk("reset_spare", 32'(spare_fault), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'hFF);
        check_map("reset_map", 8'h34, 8'h34);

        // Back-to-back failures with valid held: ready alternates 1,0,1,0
        fail_valid = 1'b1; fail_addr = 8'h12;
        #1;
        chk("seq_ready0", 32'(fail_ready), 32'd1);
        tick();
        chk("seq_ready1", 32'(fail_ready), 32'd0);
        fail_addr = 8'h34;
        tick();
        chk("seq_ready2", 32'(fail_ready), 32'd1);
        chk("seq_count1", 32'(repair_count), 32'd1);
        tick();
        chk("seq_ready3", 32'(fail_ready), 32'd0);
        fail_valid = 1'b0;
        tick();
        chk("seq_count2", 32'(repair_count), 32'd2);
        check_map("map_34", 8'h34, 8'hF1);
        check_map("map_12", 8'h12, 8'hF0);
        check_map("map_miss", 8'h56, 8'h56);
        rd_idx = 4'd1;
        #1;
        chk("rd1_addr", 32'(rd_addr), 32'h34);
        chk("rd1_valid", 32'(rd_valid), 32'd1);
        rd_idx = 4'd2;
        #1;
        chk("rd2_valid", 32'(rd_valid), 32'd0);

        user_wdata = 8'hA5; user_we = 1'b1; user_en = 1'b1; mem_rdata = 8'h3C;
        #1;
        chk("pt_wdata", 32'(mem_wdata), 32'hA5);
        chk("pt_we", 32'(mem_we), 32'd1);
        chk("pt_en", 32'(mem_en), 32'd1);
        chk("pt_rdata", 32'(user_rdata), 32'h3C);
        user_we = 1'b0; user_en = 1'b0;

        send_fail(8'h12);
        chk("dup_count", 32'(repair_count), 32'd2);
        chk("dup_ovf", 32'(repair_overflow), 32'd0);
        chk("dup_spare", 32'(spare_fault), 32'd0);

        for (int i = 0; i < 14; i++) send_fail(8'(8'h20 + i));
        chk("fill_count", 32'(repair_count), 32'd16);
        chk("fill_full", 32'(repair_full), 32'd1);
        chk("fill_ovf", 32'(repair_overflow), 32'd0);
        send_fail(8'h55);
        chk("ovf_flag", 32'(repair_overflow), 32'd1);
        chk("ovf_count", 32'(repair_count), 32'd16);
        check_map("ovf_nomap", 8'h55, 8'h55);
        check_map("map_last", 8'h2D, 8'hFF);
        rd_idx = 4'd15;
        #1;
        chk("rd15_addr", 32'(rd_addr), 32'h2D);

        send_fail(8'hF3);
        chk("spare_flag", 32'(spare_fault), 32'd1);
        chk("spare_count", 32'(repair_count), 32'd16);
        check_map("spare_pass", 8'hF3, 8'hF3);

        // Clear asserted while 0x77 is in CHECK
        fail_addr = 8'h77; fail_valid = 1'b1;
        tick();
        fail_valid = 1'b0; clear = 1'b1;
        #1;
        chk("clr_ready", 32'(fail_ready), 32'd0);
        tick();
        clear = 1'b0;
        #1;
        chk("clr_count", 32'(repair_count), 32'd0);
        chk("clr_full", 32'(repair_full), 32'd0);
        chk("clr_ovf", 32'(repair_overflow), 32'd0);
        chk("clr_spare", 32'(spare_fault), 32'd0);
        chk("clr_ready_after", 32'(fail_ready), 32'd1);
        check_map("clr_77", 8'h77, 8'h77);
        check_map("clr_34", 8'h34, 8'h34);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            chk("clr_rd_valid", 32'(rd_valid), 32'd0);
        end
        tick();
        chk("clr_count_hold", 32'(repair_count), 32'd0);

        send_fail(8'h77);
        chk("post_clr_count", 32'(repair_count), 32'd1);
        check_map("post_clr_map", 8'h77, 8'hF0);

        lock = 1'b1; fail_valid = 1'b1; fail_addr = 8'h88;
        #1;
        chk("lock_ready", 32'(fail_ready), 32'd0);
        tick(); tick(); tick();
        chk("lock_count", 32'(repair_count), 32'd1);
        fail_valid = 1'b0; lock = 1'b0;
        check_map("lock_nomap", 8'h88, 8'h88);

        // Lock raised during an in-flight CHECK lets it finish
        fail_valid = 1'b1; fail_addr = 8'h99;
        tick();
        fail_valid = 1'b0; lock = 1'b1;
        tick();
        chk("lock_inflight", 32'(repair_count), 32'd2);
        check_map("lock_inflight_map", 8'h99, 8'hF1);
        lock = 1'b0;

        fail_valid = 1'b1; fail_addr = 8'hAA;
        tick();
        fail_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_count", 32'(repair_count), 32'd0);
        chk("rst_ready", 32'(fail_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("rst_drop", 32'(repair_count), 32'd0);
        check_map("rst_nomap", 8'hAA, 8'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
